// File: rtl/mar_ctrl.sv
// mar_ctrl: memory address register with prioritised loads, increment and req/ack access handshake
module mar_ctrl #(
    parameter int ADDR_W   = 8,
    parameter int NUM_SRC  = 2,
    parameter int AUTO_INC = 1,
    parameter int TIMEOUT  = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_SRC*ADDR_W-1:0] src_addr,
    input  logic [NUM_SRC-1:0]        src_load,
    input  logic                      inc,
    input  logic                      acc_start,
    input  logic                      mem_ack,
    input  logic                      clr_err,
    output logic [ADDR_W-1:0]         mar_data,
    output logic                      mem_req,
    output logic                      busy,
    output logic                      timeout,
    output logic                      load_err
);
    localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
    typedef enum logic {IDLE, REQ} state_t;
    state_t            state, state_nx;
    logic [ADDR_W-1:0] addr_nx, sel_addr;
    logic [CW-1:0]     cnt, cnt_nx;
    logic              to_nx, err_nx;
    // Scan from the top so the lowest asserted index wins
    always_comb begin
        sel_addr = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--)
            if (src_load[i]) sel_addr = src_addr[i*ADDR_W +: ADDR_W];
    end
    always_comb begin
        state_nx = state;
        addr_nx  = mar_data;
        cnt_nx   = cnt;
        to_nx    = 1'b0;
        err_nx   = load_err & ~clr_err;
        if (state == IDLE) begin
            addr_nx = |src_load ? sel_addr : inc ? mar_data + ADDR_W'(1) : mar_data;
            if (acc_start) begin
                state_nx = REQ;
                cnt_nx   = '0;
            end
        end else begin
            if (|src_load || inc) err_nx = 1'b1;
            if (mem_ack) begin
                state_nx = IDLE;
                if (AUTO_INC != 0) addr_nx = mar_data + ADDR_W'(1);
            end else if (TIMEOUT > 0 && cnt == CW'(TIMEOUT - 1)) begin
                state_nx = IDLE;
                to_nx    = 1'b1;
            end else begin
                cnt_nx = cnt + CW'(1);
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            mar_data <= '0;
            cnt      <= '0;
            timeout  <= 1'b0;
            load_err <= 1'b0;
        end else begin
            state    <= state_nx;
            mar_data <= addr_nx;
            cnt      <= cnt_nx;
            timeout  <= to_nx;
            load_err <= err_nx;
        end
    end
    assign mem_req = state == REQ;
    assign busy    = mem_req;
endmodule

// File: tb/tb_mar_ctrl.sv
// tb_mar_ctrl: directed checks of mar_ctrl loads, increment wrap, handshake, timeout and error flag
module tb_mar_ctrl;
    logic        clk = 0, rst = 1;
    logic [15:0] src_addr = '0;
    logic [1:0]  src_load = '0;
    logic        inc = 0, acc_start = 0, mem_ack = 0, clr_err = 0;
    logic [7:0]  mar_data;
    logic        mem_req, busy, timeout, load_err;
    int          checks = 0, failures = 0;

    mar_ctrl #(.ADDR_W(8), .NUM_SRC(2), .AUTO_INC(1), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .src_addr(src_addr), .src_load(src_load), .inc(inc),
        .acc_start(acc_start), .mem_ack(mem_ack), .clr_err(clr_err), .mar_data(mar_data),
        .mem_req(mem_req), .busy(busy), .timeout(timeout), .load_err(load_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset overrides every other input
        src_load = 2'b11; inc = 1; acc_start = 1; mem_ack = 1;
        step;
        check("rst_mar", mar_data, 0);
        check("rst_req", mem_req, 0);
        check("rst_busy", busy, 0);
        check("rst_to", timeout, 0);
        check("rst_err", load_err, 0);
        step;
        check("rst_req_hold", mem_req, 0);
        rst = 0; src_load = 0; inc = 0; acc_start = 0; mem_ack = 0;
        step;
        // Priority: src0 > src1 > inc
        src_addr = {8'h20, 8'h10}; src_load = 2'b11;
        step;
        check("prio_src0", mar_data, 8'h10);
        src_load = 2'b10; inc = 1;
        step;
        check("load_beats_inc", mar_data, 8'h20);
        // Increment wrap
        src_addr[7:0] = 8'hFF; src_load = 2'b01; inc = 0;
        step;
        check("load_ff", mar_data, 8'hFF);
        src_load = 0; inc = 1;
        step;
        check("inc_wrap", mar_data, 8'h00);
        step;
        check("inc_after_wrap", mar_data, 8'h01);
        inc = 0;
        // Load + start, ack on third REQ cycle
        src_addr[7:0] = 8'h40; src_load = 2'b01; acc_start = 1;
        step;
        check("acc_req_c1", mem_req, 1);
        check("acc_mar", mar_data, 8'h40);
        src_load = 0; acc_start = 0;
        step;
        check("acc_req_c2", mem_req, 1);
        step;
        check("acc_req_c3", busy, 1);
        mem_ack = 1;
        step;
        check("ack_req", mem_req, 0);
        check("ack_busy", busy, 0);
        check("ack_autoinc", mar_data, 8'h41);
        mem_ack = 0;
        // Timeout with no ack
        acc_start = 1;
        step;
        acc_start = 0;
        check("to_req_c1", mem_req, 1);
        for (int i = 2; i <= 4; i++) begin
            step;
            check($sformatf("to_req_c%0d", i), mem_req, 1);
            check($sformatf("to_nopulse_c%0d", i), timeout, 0);
        end
        step;
        check("to_req_drop", mem_req, 0);
        check("to_pulse", timeout, 1);
        check("to_mar_hold", mar_data, 8'h41);
        step;
        check("to_pulse_end", timeout, 0);
        // Ack in final timeout cycle wins
        acc_start = 1;
        step;
        acc_start = 0;
        step;
        step;
        step;
        check("late_req_c4", mem_req, 1);
        mem_ack = 1;
        step;
        check("late_ack_req", mem_req, 0);
        check("late_ack_nopulse", timeout, 0);
        check("late_ack_inc", mar_data, 8'h42);
        mem_ack = 0;
        step;
        check("late_ack_nopulse2", timeout, 0);
        // Load attempt during REQ
        acc_start = 1;
        step;
        acc_start = 0;
        src_addr[7:0] = 8'h99; src_load = 2'b01;
        step;
        check("busy_load_mar", mar_data, 8'h42);
        check("busy_load_err", load_err, 1);
        src_load = 0; mem_ack = 1;
        step;
        check("err_after_ack", load_err, 1);
        check("ack2_mar", mar_data, 8'h43);
        mem_ack = 0; clr_err = 1;
        step;
        check("clr_err", load_err, 0);
        clr_err = 0;
        // Set beats clear; inc frozen in REQ
        acc_start = 1;
        step;
        acc_start = 0; inc = 1; clr_err = 1;
        step;
        check("set_beats_clr", load_err, 1);
        check("busy_inc_mar", mar_data, 8'h43);
        inc = 0; clr_err = 0;
        rst = 1;
        step;
        check("midreq_rst_req", mem_req, 0);
        check("midreq_rst_mar", mar_data, 0);
        check("midreq_rst_err", load_err, 0);
        rst = 0; mem_ack = 1;
        step;
        check("idle_ack_mar", mar_data, 0);
        check("idle_ack_req", mem_req, 0);
        mem_ack = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
